wb_kv_initiator: RTL
====================

# wb_kv_initiator

Wishbone classic single-transfer initiator that issues read/write cycles toward the keyvalue responder (or any Wishbone responder) on behalf of a simple valid/ready command port. It sits on the project side of the Caravel wrapper and is the bus master for self-test and loopback of the keyvalue store: command words arrive from the logic-analyzer/IO glue, and each command yields exactly one Wishbone cycle and exactly one response. One transfer is in flight at a time.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting for ack (only with timeout feature); legal 1..255
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  target address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  32  read data (0 for writes and errors)
- rsp_err_o  out  1  transfer timed out (qualified by rsp_valid_o)
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle/strobe/write enable
- wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32  Wishbone select/address/write data
- wbm_dat_i  in  32; wbm_ack_i  in  1  Wishbone read data/ack
- busy_o  out  1  high whenever state != IDLE

## Operation
- FSM states IDLE, BUS, RESP; reset state IDLE.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch we/adr/dat/sel into wbm_* registers, set cyc=stb=1, go BUS.
- BUS: cmd_ready_o=0; cyc, stb, we, sel, adr, dat held stable. On wbm_ack_i: capture wbm_dat_i into rsp_dat_o if read (0 if write), clear cyc/stb, rsp_err_o=0, go RESP.
- RESP: rsp_valid_o=1 for exactly this cycle; go IDLE.
- wbm_ack_i outside BUS ignored; no state change, no response.
- rsp_dat_o/rsp_err_o hold their value until the next RESP.
- wbm_dat_o driven with latched data for reads too (don't-care to responder).

## Timing
- Reset values: cmd_ready_o=1 after reset released (0 while wb_rst_i high), rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, all wbm_* outputs 0, busy_o=0.
- Command accepted at edge N → cyc/stb high from cycle N+1.
- Ack sampled at edge K → cyc/stb low from K+1, rsp_valid_o high in cycle K+1, cmd_ready_o high in K+2.
- Zero-wait responder (ack in first BUS cycle): command-to-response 2 cycles; back-to-back throughput one transfer per 3 cycles.
- Reset mid-transfer: cyc/stb low after the reset edge, no response emitted, latched command discarded.

## Configuration
- WB_TIMEOUT_EN defined: 8-bit counter cleared on entry to BUS, increments each BUS cycle without ack; when count reaches TIMEOUT_CYCLES with no ack, clear cyc/stb, rsp_dat_o=0, rsp_err_o=1, go RESP. Ack in same cycle as expiry wins (normal completion, err=0).
- Undefined: no counter, BUS waits indefinitely; rsp_err_o tied 0.

## Structure
- Package wb_kv_pkg: FSM state enum (IDLE, BUS, RESP), WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, default timeout constant.
- Sub-module wb_timeout_ctr (clear, enable, limit in; expired out), instantiated only under WB_TIMEOUT_EN.

## Test plan
- Write adr=0x3000_0000 dat=0x0001_0000 sel=0xF, responder acks 1st BUS cycle → one cyc/stb pulse with we=1 and those values; rsp_valid 2 cycles after accept, rsp_dat=0, err=0.
- Read adr=0x3000_0004, responder acks after 3 waits with dat=0xA5A5_5A5A → adr/sel stable 4 cycles, rsp_dat=0xA5A5_5A5A, cmd_ready low throughout.
- Two back-to-back commands with cmd_valid held → second cyc starts exactly 3 cycles after first; no lost or duplicate response.
- Spurious wbm_ack_i in IDLE and in RESP → no response, state unchanged.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → cyc drops after 4 BUS cycles, rsp_valid with err=1, dat=0; repeat with ack on expiry cycle → err=0.
- wb_rst_i asserted in 2nd BUS cycle → next cycle cyc/stb=0, busy_o=0, no rsp_valid; fresh command afterwards completes normally.

Source files
------------

// File: rtl/wb_kv_pkg.sv
// Shared types and widths for the Wishbone keyvalue initiator.
package wb_kv_pkg;

  localparam int WB_ADR_W           = 32;
  localparam int WB_DAT_W           = 32;
  localparam int WB_SEL_W           = 4;
  localparam int WB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack-wait timer for the initiator; only built when WB_TIMEOUT_EN is defined.
// Down-counter reloaded to limit-1 while clear is high; expired marks the limit-th enabled cycle.
`ifdef WB_TIMEOUT_EN
module wb_timeout_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= limit - 8'd1;
    end else if (enable && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = enable && (count == 8'd0);

endmodule
`endif

// File: rtl/wb_kv_initiator.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | ready for a command, bus idle
//   BUS   | cyc/stb asserted, waiting for ack (or timeout)
//   RESP  | one-cycle response pulse, then back to IDLE
module wb_kv_initiator
   import wb_kv_pkg::*;
   #(parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT)
(
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [WB_ADR_W-1:0] cmd_adr_i,
   input  logic [WB_DAT_W-1:0] cmd_dat_i,
   input  logic [WB_SEL_W-1:0] cmd_sel_i,
   output logic                rsp_valid_o,
   output logic [WB_DAT_W-1:0] rsp_dat_o,
   output logic                rsp_err_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [WB_SEL_W-1:0] wbm_sel_o,
   output logic [WB_ADR_W-1:0] wbm_adr_o,
   output logic [WB_DAT_W-1:0] wbm_dat_o,
   input  logic [WB_DAT_W-1:0] wbm_dat_i,
   input  logic                wbm_ack_i,
   output logic                busy_o
);

   wb_state_t state;

   assign cmd_ready_o = (state == IDLE) && !wb_rst_i;
   assign busy_o      = (state != IDLE);

`ifdef WB_TIMEOUT_EN
   logic expired;
   logic err;

   wb_timeout_ctr u_timeout (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (state != BUS),
      .enable  (state == BUS),
      .limit   (8'(TIMEOUT_CYCLES)),
      .expired (expired)
   );

   assign rsp_err_o = err;
`else
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
`ifdef WB_TIMEOUT_EN
         err         <= 1'b0;
`endif
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  wbm_we_o  <= cmd_we_i;
                  wbm_adr_o <= cmd_adr_i;
                  wbm_dat_o <= cmd_dat_i;
                  wbm_sel_o <= cmd_sel_i;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  state     <= BUS;
               end
            end
            BUS: begin
               if (wbm_ack_i) begin
                  rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
`ifdef WB_TIMEOUT_EN
                  err         <= 1'b0;
`endif
                  state       <= RESP;
               end
`ifdef WB_TIMEOUT_EN
               else if (expired) begin
                  rsp_dat_o   <= '0;
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  err         <= 1'b1;
                  state       <= RESP;
               end
`endif
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
